board_ctl: RTL and testbench

//  Playfield side of the falling-piece interface. Consumes piece state (xpos, ypos, block, rot, lock_en)

---
 rtl/board_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_board_ctl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctl.sv
// Playfield controller: piece geometry, collision probe, occupancy grid, lock and line-clear FSM.
// Optional feature macro: BOARD_SCORE_EN adds a saturating score output.
module board_ctl #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic [3:0]      xpos,
    input  logic [4:0]      ypos,
    input  logic [4:0]      block,
    input  logic [1:0]      rot,
    input  logic            lock_en,
    output logic [3:0]      sq_1_col,
    output logic [3:0]      sq_2_col,
    output logic [3:0]      sq_3_col,
    output logic [3:0]      sq_4_col,
    output logic            collision,
    input  logic [4:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            busy,
    output logic [2:0]      lines_cleared,
    output logic            line_pulse,
    output logic            game_over
`ifdef BOARD_SCORE_EN
    ,
    output logic [19:0]     score
`endif
);

    localparam logic [3:0] COLS_W   = 4'(COLS);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, DONE} state_t;

    state_t          state, state_next;
    logic [COLS-1:0] grid [ROWS];
    logic            lock_q;
    logic            lock_rise;
    logic [4:0]      scan_r;
    logic [4:0]      src;
    logic [2:0]      cnt;
    logic [3:0]      col [4];
    logic [5:0]      row [4];
    logic [3:0]      in_board;
    logic            coll_next;
    logic            lock_over;

    assign lock_rise = lock_en & ~lock_q;
    assign sq_1_col  = col[0];
    assign sq_2_col  = col[1];
    assign sq_3_col  = col[2];
    assign sq_4_col  = col[3];

    // Rows are 6-bit two's complement so pieces poking above row 0 read as negative.
    always_comb begin : shape
        logic signed [2:0] bdx [4];
        logic signed [2:0] bdy [4];
        logic signed [2:0] rx, ry, tmp;
        logic [1:0]        turns;
        // NOTE: combinational blocks use blocking '=' so each step sees the value just computed.
        bdx   = '{default: '0};
        bdy   = '{default: '0};
        rx    = '0;
        ry    = '0;
        tmp   = '0;
        turns = rot;
        case (block)
            5'b10000: bdx = '{-3'sd1, 3'sd0, 3'sd1, 3'sd2};
            5'b10001: begin
                bdx   = '{3'sd0, 3'sd1, 3'sd0, 3'sd1};
                bdy   = '{3'sd0, 3'sd0, 3'sd1, 3'sd1};
                turns = 2'd0;
            end
            5'b10010: begin bdx = '{-3'sd1, 3'sd0, 3'sd1, 3'sd0};  bdy = '{3'sd0, 3'sd0, 3'sd0, 3'sd1}; end
            5'b10011: begin bdx = '{3'sd0, 3'sd1, -3'sd1, 3'sd0};  bdy = '{3'sd0, 3'sd0, 3'sd1, 3'sd1}; end
            5'b10100: begin bdx = '{-3'sd1, 3'sd0, 3'sd0, 3'sd1};  bdy = '{3'sd0, 3'sd0, 3'sd1, 3'sd1}; end
            5'b10101: begin bdx = '{-3'sd1, 3'sd0, 3'sd1, 3'sd1};  bdy = '{3'sd0, 3'sd0, 3'sd0, 3'sd1}; end
            5'b10110: begin bdx = '{-3'sd1, 3'sd0, 3'sd1, -3'sd1}; bdy = '{3'sd0, 3'sd0, 3'sd0, 3'sd1}; end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            rx = bdx[i];
            ry = bdy[i];
            for (int r = 0; r < 3; r++) begin
                if (2'(r) < turns) begin
                    tmp = rx;
                    rx  = -ry;
                    ry  = tmp;
                end
            end
            col[i] = xpos + {rx[2], rx};
            row[i] = {1'b0, ypos} + {{3{ry[2]}}, ry};
        end
    end

    always_comb begin : probe
        logic [5:0] nrow;
        nrow      = '0;
        coll_next = 1'b0;
        lock_over = 1'b0;
        in_board  = '0;
        for (int i = 0; i < 4; i++) begin
            nrow = row[i] + 6'd1;
            if (col[i] >= COLS_W) begin
                coll_next = 1'b1;
            end else if (!nrow[5]) begin
                if (nrow >= ROWS_W || grid[nrow[4:0]][col[i]])
                    coll_next = 1'b1;
            end
            in_board[i] = !row[i][5] && (row[i] < ROWS_W) && (col[i] < COLS_W);
            if (row[i][5] || (in_board[i] && grid[row[i][4:0]][col[i]]))
                lock_over = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lock_rise) state_next = LOCK;
            LOCK:    state_next = SCAN;
            SCAN: begin
                if (&grid[scan_r])     state_next = SHIFT;
                else if (scan_r == '0) state_next = DONE;
            end
            SHIFT:   if (src == '0) state_next = SCAN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        line_pulse    = (state == DONE);
        lines_cleared = (state == DONE) ? cnt : 3'd0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            collision <= 1'b0;
            rd_data   <= '0;
            game_over <= 1'b0;
            scan_r    <= '0;
            src       <= '0;
            cnt       <= '0;
            // NOTE: the grid is board state, not scratch RAM, so every row is cleared on reset.
            for (int r = 0; r < ROWS; r++) grid[r] <= '0;
        end else begin
            lock_q    <= lock_en;
            collision <= coll_next;
            rd_data   <= ({1'b0, rd_row} < ROWS_W) ? grid[rd_row] : '0;
            case (state)
                LOCK: begin
                    for (int i = 0; i < 4; i++)
                        if (in_board[i]) grid[row[i][4:0]][col[i]] <= 1'b1;
                    if (lock_over) game_over <= 1'b1;
                    scan_r <= LAST_ROW;
                    cnt    <= '0;
                end
                SCAN: begin
                    if (&grid[scan_r]) begin
                        cnt <= cnt + 3'd1;
                        src <= scan_r;
                    end else if (scan_r != '0) begin
                        scan_r <= scan_r - 5'd1;
                    end
                end
                SHIFT: begin
                    if (src == '0) begin
                        grid[0] <= '0;
                    end else begin
                        grid[src] <= grid[src - 5'd1];
                        src       <= src - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOARD_SCORE_EN
    logic [10:0] pts;
    logic [20:0] score_sum;

    always_comb begin
        case (cnt)
            3'd1:    pts = 11'd40;
            3'd2:    pts = 11'd100;
            3'd3:    pts = 11'd300;
            3'd4:    pts = 11'd1200;
            default: pts = 11'd0;
        endcase
        score_sum = {1'b0, score} + {10'b0, pts};
    end

    // Committed on entry to DONE so the new total is visible alongside line_pulse.
    always_ff @(posedge pclk) begin
        if (rst)
            score <= '0;
        else if (state == SCAN && state_next == DONE)
            score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end
`endif

endmodule

// File: tb/tb_board_ctl.sv
// Directed bench for board_ctl: geometry, collision, lock, line clear, game over, reset abort.
module tb_board_ctl;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    localparam logic [4:0] B_I = 5'b10000;
    localparam logic [4:0] B_O = 5'b10001;
    localparam logic [4:0] B_T = 5'b10010;
    localparam logic [4:0] B_S = 5'b10011;
    localparam logic [4:0] B_J = 5'b10101;

    logic            pclk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      xpos = '0;
    logic [4:0]      ypos = '0;
    logic [4:0]      block = '0;
    logic [1:0]      rot = '0;
    logic            lock_en = 1'b0;
    logic [3:0]      sq_1_col, sq_2_col, sq_3_col, sq_4_col;
    logic            collision;
    logic [4:0]      rd_row = '0;
    logic [COLS-1:0] rd_data;
    logic            busy;
    logic [2:0]      lines_cleared;
    logic            line_pulse;
    logic            game_over;
`ifdef BOARD_SCORE_EN
    logic [19:0]     score;
`endif

    board_ctl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .pclk          (pclk),
        .rst           (rst),
        .xpos          (xpos),
        .ypos          (ypos),
        .block         (block),
        .rot           (rot),
        .lock_en       (lock_en),
        .sq_1_col      (sq_1_col),
        .sq_2_col      (sq_2_col),
        .sq_3_col      (sq_3_col),
        .sq_4_col      (sq_4_col),
        .collision     (collision),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .busy          (busy),
        .lines_cleared (lines_cleared),
        .line_pulse    (line_pulse),
        .game_over     (game_over)
`ifdef BOARD_SCORE_EN
        ,
        .score         (score)
`endif
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst     = 1'b1;
        lock_en = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic set_piece(input logic [4:0] b, input logic [1:0] r, input logic [3:0] x, input logic [4:0] y);
        @(negedge pclk);
        block = b;
        rot   = r;
        xpos  = x;
        ypos  = y;
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic check_cols(input string tag, input logic [15:0] exp);
        check(tag, {16'h0, sq_1_col, sq_2_col, sq_3_col, sq_4_col}, {16'h0, exp});
    endtask

    task automatic read_row(input int r, output logic [COLS-1:0] v);
        @(negedge pclk);
        rd_row = 5'(r);
        @(posedge pclk);
        @(negedge pclk);
        v = rd_data;
    endtask

    task automatic grid_or(output logic [COLS-1:0] acc);
        logic [COLS-1:0] v;
        acc = '0;
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, v);
            acc = acc | v;
        end
    endtask

    // Raises lock_en for one cycle and waits (bounded) for line_pulse.
    task automatic do_lock(input logic [4:0] b, input logic [1:0] r, input logic [3:0] x,
                           input logic [4:0] y, output int cycles, output logic [2:0] lc);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        lc     = '0;
        @(negedge pclk);
        block   = b;
        rot     = r;
        xpos    = x;
        ypos    = y;
        lock_en = 1'b1;
        while (!seen && cycles < 400) begin
            @(posedge pclk);
            @(negedge pclk);
            cycles++;
            lock_en = 1'b0;
            if (line_pulse) begin
                seen = 1'b1;
                lc   = lines_cleared;
            end
        end
        if (!seen) check("lock_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int              cyc;
        int              pulses;
        int              lsum;
        logic [2:0]      lc;
        logic [COLS-1:0] v;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_pulse", line_pulse, 0);
        check("rst_lines", lines_cleared, 0);
        check("rst_game_over", game_over, 0);
        check("rst_collision", collision, 0);
        check("rst_rd_data", rd_data, 0);

        // Geometry and collision on an empty board
        set_piece(B_T, 2'd0, 4'd5, 5'd18);
        check_cols("t_cols", 16'h4565);
        check("t_floor_coll", collision, 1);
        set_piece(B_T, 2'd0, 4'd5, 5'd17);
        check("t_free_coll", collision, 0);
        set_piece(B_I, 2'd0, 4'd8, 5'd5);
        check_cols("i_wall_cols", 16'h789A);
        check("i_wall_coll", collision, 1);
        set_piece(B_J, 2'd2, 4'd5, 5'd5);
        check_cols("j_rot2_cols", 16'h6544);
        set_piece(B_S, 2'd3, 4'd3, 5'd5);
        check_cols("s_rot3_cols", 16'h3344);
        set_piece(B_O, 2'd3, 4'd5, 5'd5);
        check_cols("o_rot3_cols", 16'h5656);
        set_piece(5'h00, 2'd1, 4'd3, 5'd5);
        check_cols("undef_cols", 16'h3333);

        // Vertical I at column 0: rows 4..7
        do_reset();
        set_piece(B_I, 2'd1, 4'd0, 5'd5);
        check_cols("ivert_cols", 16'h0000);
        do_lock(B_I, 2'd1, 4'd0, 5'd5, cyc, lc);
        check("ivert_latency", cyc, 22);
        check("ivert_lines", lc, 0);
        read_row(3, v); check("ivert_row3", v, 10'h000);
        read_row(4, v); check("ivert_row4", v, 10'h001);
        read_row(7, v); check("ivert_row7", v, 10'h001);
        read_row(8, v); check("ivert_row8", v, 10'h000);
        read_row(25, v); check("rd_out_of_range", v, 10'h000);
        check("ivert_game_over", game_over, 0);

        // Single line clear: row 19 cols 0..5 then I fills 6..9
        do_reset();
        do_lock(B_I, 2'd0, 4'd1, 5'd19, cyc, lc);
        do_lock(B_O, 2'd0, 4'd4, 5'd18, cyc, lc);
        do_lock(B_I, 2'd0, 4'd7, 5'd19, cyc, lc);
        check("clr1_latency", cyc, 43);
        check("clr1_lines", lc, 1);
        read_row(19, v); check("clr1_row19", v, 10'h030);
        read_row(18, v); check("clr1_row18", v, 10'h000);
        read_row(0, v);  check("clr1_row0", v, 10'h000);
        set_piece(B_O, 2'd0, 4'd4, 5'd17);
        check("occupied_coll", collision, 1);
        set_piece(B_O, 2'd0, 4'd6, 5'd17);
        check("beside_coll", collision, 0);

        // Four-line clear: rows 16..19 cols 1..9, then vertical I in column 0
        do_reset();
        lsum = 0;
        for (int c = 1; c < COLS; c++) begin
            do_lock(B_I, 2'd1, 4'(c), 5'd17, cyc, lc);
            lsum += int'(lc);
        end
        check("pre4_lines", lsum, 0);
        do_lock(B_I, 2'd1, 4'd0, 5'd17, cyc, lc);
        check("clr4_latency", cyc, 106);
        check("clr4_lines", lc, 4);
        grid_or(v);
        check("clr4_grid_empty", v, 10'h000);
        check("clr4_game_over", game_over, 0);
`ifdef BOARD_SCORE_EN
        check("clr4_score", score, 1200);
`endif

        // Game over above the board, then reset during SHIFT
        do_reset();
        do_lock(B_O, 2'd0, 4'd5, 5'h1F, cyc, lc);
        check("over_game_over", game_over, 1);
        check("over_lines", lc, 0);
        do_lock(B_I, 2'd0, 4'd1, 5'd19, cyc, lc);
        do_lock(B_O, 2'd0, 4'd4, 5'd18, cyc, lc);
        check("over_fsm_runs", lc, 0);
        @(negedge pclk);
        block   = B_I;
        rot     = 2'd0;
        xpos    = 4'd7;
        ypos    = 5'd19;
        lock_en = 1'b1;
        repeat (5) begin
            @(posedge pclk);
            @(negedge pclk);
            lock_en = 1'b0;
        end
        check("shift_busy", busy, 1);
        rst = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_game_over", game_over, 0);
        pulses = 0;
        repeat (60) begin
            @(posedge pclk);
            @(negedge pclk);
            if (line_pulse) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        grid_or(v);
        check("abort_grid_empty", v, 10'h000);

        // Second lock edge while busy is ignored
        do_reset();
        @(negedge pclk);
        block   = B_T;
        rot     = 2'd0;
        xpos    = 4'd5;
        ypos    = 5'd10;
        lock_en = 1'b1;
        @(posedge pclk); @(negedge pclk);
        lock_en = 1'b0;
        @(posedge pclk); @(negedge pclk);
        @(posedge pclk); @(negedge pclk);
        lock_en = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(posedge pclk);
            @(negedge pclk);
            lock_en = 1'b0;
            if (line_pulse) pulses++;
        end
        check("dbl_pulses", pulses, 1);
        check("dbl_game_over", game_over, 0);
        read_row(10, v); check("dbl_row10", v, 10'h070);
        read_row(11, v); check("dbl_row11", v, 10'h020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
